// File: rtl/decode_stage.sv
// RISC-V instruction decode stage: register file with write-through bypass,
// immediate/control generation, load-use hazard detection and the ID/EX register.
module decode_stage #(
    parameter logic [31:0] NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruccion,
    input  logic [31:0] pc4,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc4,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [2:0]  id_funct3,
    output logic        id_funct7b5,
    output logic [6:0]  id_opcode,
    output logic        id_regwrite,
    output logic        id_memread,
    output logic        id_memwrite,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_alusrc,
    output logic        id_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [6:0]  opcode;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic        alusrc;
        logic        illegal;
    } idex_t;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    idex_t       idex_q;
    idex_t       idex_d;
    idex_t       dec;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    // Reads below use regs_d, so a same-cycle writeback is seen by the decode.
    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_rd != 5'd0)) begin
            regs_d[wb_rd] = wb_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign imm_i = {{20{instruccion[31]}}, instruccion[31:20]};
    assign imm_s = {{20{instruccion[31]}}, instruccion[31:25], instruccion[11:7]};
    assign imm_b = {{19{instruccion[31]}}, instruccion[31], instruccion[7],
                    instruccion[30:25], instruccion[11:8], 1'b0};
    assign imm_u = {instruccion[31:12], 12'h000};
    assign imm_j = {{11{instruccion[31]}}, instruccion[31], instruccion[19:12],
                    instruccion[20], instruccion[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        dec.valid    = 1'b1;
        dec.pc4      = pc4;
        dec.rd       = instruccion[11:7];
        dec.rs1      = instruccion[19:15];
        dec.rs2      = instruccion[24:20];
        dec.funct3   = instruccion[14:12];
        dec.funct7b5 = instruccion[30];
        dec.opcode   = instruccion[6:0];
        dec.rs1_data = regs_d[instruccion[19:15]];
        dec.rs2_data = regs_d[instruccion[24:20]];
        case (instruccion[6:0])
            OP_R: begin
                dec.regwrite = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_I: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_i;
                uses_rs1     = 1'b1;
            end
            OP_LOAD: begin
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_i;
                uses_rs1     = 1'b1;
            end
            OP_STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_s;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.imm      = imm_b;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_JAL: begin
                dec.regwrite = 1'b1;
                dec.jump     = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_j;
            end
            OP_JALR: begin
                dec.regwrite = 1'b1;
                dec.jump     = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_i;
                uses_rs1     = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_u;
            end
            default: begin
                dec.illegal  = 1'b1;
            end
        endcase
        dec.regwrite = dec.regwrite && (dec.rd != 5'd0);
    end

    // A NOP never stalls; with the default encoding it has no real source anyway.
    assign stall = idex_q.valid && idex_q.memread && (idex_q.rd != 5'd0) && !flush &&
                   (instruccion != NOP) &&
                   ((uses_rs1 && (dec.rs1 == idex_q.rd)) ||
                    (uses_rs2 && (dec.rs2 == idex_q.rd)));

    always_comb begin
        idex_d = dec;
        if (flush || stall) begin
            idex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign id_valid    = idex_q.valid;
    assign id_pc4      = idex_q.pc4;
    assign id_rs1_data = idex_q.rs1_data;
    assign id_rs2_data = idex_q.rs2_data;
    assign id_imm      = idex_q.imm;
    assign id_rd       = idex_q.rd;
    assign id_rs1      = idex_q.rs1;
    assign id_rs2      = idex_q.rs2;
    assign id_funct3   = idex_q.funct3;
    assign id_funct7b5 = idex_q.funct7b5;
    assign id_opcode   = idex_q.opcode;
    assign id_regwrite = idex_q.regwrite;
    assign id_memread  = idex_q.memread;
    assign id_memwrite = idex_q.memwrite;
    assign id_branch   = idex_q.branch;
    assign id_jump     = idex_q.jump;
    assign id_alusrc   = idex_q.alusrc;
    assign id_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model predicts stall and the
// ID/EX contents for every issued instruction; a monitor compares them.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruccion;
    logic [31:0] pc4;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc4, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic [6:0]  id_opcode;
    logic        id_regwrite, id_memread, id_memwrite, id_branch, id_jump, id_alusrc, id_illegal;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [6:0]  opcode;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic        alusrc;
        logic        illegal;
    } slot_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    slot_t idex_exp_q [$];
    bit    stall_exp_q [$];

    logic [31:0] mregs [32];
    slot_t       mslot;
    bit          last_stall;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .instruccion(instruccion), .pc4(pc4), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_opcode(id_opcode), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_branch(id_branch), .id_jump(id_jump),
        .id_alusrc(id_alusrc), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic slot_t sample_dut();
        slot_t s;
        s = '{id_valid, id_pc4, id_rs1_data, id_rs2_data, id_imm, id_rd, id_rs1, id_rs2,
              id_funct3, id_funct7b5, id_opcode, id_regwrite, id_memread, id_memwrite,
              id_branch, id_jump, id_alusrc, id_illegal};
        return s;
    endfunction

    function automatic string kind_of(logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: return "R";
            7'b0010011: return "I";
            7'b0000011: return "LOAD";
            7'b0100011: return "STORE";
            7'b1100011: return "BRANCH";
            7'b1101111: return "JAL";
            7'b1100111: return "JALR";
            7'b0110111: return "LUI";
            7'b0010111: return "AUIPC";
            default:    return "UNKNOWN";
        endcase
    endfunction

    function automatic bit reads_rs1(logic [31:0] ins);
        string k = kind_of(ins);
        return k == "R" || k == "I" || k == "LOAD" || k == "STORE" || k == "BRANCH" || k == "JALR";
    endfunction

    function automatic bit reads_rs2(logic [31:0] ins);
        string k = kind_of(ins);
        return k == "R" || k == "STORE" || k == "BRANCH";
    endfunction

    function automatic int sext(logic [31:0] v, int bits);
        int u = int'(v) & ((1 << bits) - 1);
        if (u >= (1 << (bits - 1))) u = u - (1 << bits);
        return u;
    endfunction

    // Expected decode of one instruction, against the model register file.
    function automatic slot_t model_decode(logic [31:0] ins, logic [31:0] pc);
        slot_t r = '0;
        string k = kind_of(ins);
        r.valid    = 1'b1;
        r.pc4      = pc;
        r.rd       = ins[11:7];
        r.rs1      = ins[19:15];
        r.rs2      = ins[24:20];
        r.funct3   = ins[14:12];
        r.funct7b5 = ins[30];
        r.opcode   = ins[6:0];
        r.rs1_data = mregs[ins[19:15]];
        r.rs2_data = mregs[ins[24:20]];
        if (k == "I" || k == "LOAD" || k == "JALR") r.imm = sext(ins >> 20, 12);
        if (k == "STORE")  r.imm = sext(((ins >> 25) << 5) | ((ins >> 7) & 32'h1F), 12);
        if (k == "BRANCH") r.imm = sext((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                                        (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1), 13);
        if (k == "LUI" || k == "AUIPC") r.imm = ins & 32'hFFFFF000;
        if (k == "JAL") r.imm = sext((((ins >> 31) & 1) << 20) | (((ins >> 12) & 32'hFF) << 12) |
                                     (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3FF) << 1), 21);
        r.regwrite = (k == "R" || k == "I" || k == "LOAD" || k == "JAL" || k == "JALR" ||
                      k == "LUI" || k == "AUIPC") && (r.rd != 0);
        r.memread  = (k == "LOAD");
        r.memwrite = (k == "STORE");
        r.branch   = (k == "BRANCH");
        r.jump     = (k == "JAL" || k == "JALR");
        r.alusrc   = !(k == "R" || k == "BRANCH" || k == "UNKNOWN");
        r.illegal  = (k == "UNKNOWN");
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mslot      = '0;
        last_stall = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc, input bit fl,
                                 input bit we, input logic [4:0] wrd, input logic [31:0] wdat);
        bit    st;
        slot_t nxt;
        @(negedge clk);
        instruccion = ins;
        pc4         = pc;
        flush       = fl;
        wb_en       = we;
        wb_rd       = wrd;
        wb_data     = wdat;
        st = !fl && mslot.valid && mslot.memread && (mslot.rd != 0) &&
             ((reads_rs1(ins) && ins[19:15] == mslot.rd) || (reads_rs2(ins) && ins[24:20] == mslot.rd));
        if (we && wrd != 0) mregs[wrd] = wdat;
        nxt = (fl || st) ? slot_t'('0) : model_decode(ins, pc);
        stall_exp_q.push_back(st);
        idex_exp_q.push_back(nxt);
        mslot      = nxt;
        last_stall = st;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 11))
            0, 1:    r[6:0] = 7'b0000011;
            2:       r[6:0] = 7'b0110011;
            3:       r[6:0] = 7'b0010011;
            4:       r[6:0] = 7'b0100011;
            5:       r[6:0] = 7'b1100011;
            6:       r[6:0] = 7'b1101111;
            7:       r[6:0] = 7'b1100111;
            8:       r[6:0] = 7'b0110111;
            9:       r[6:0] = 7'b0010111;
            10:      r[6:0] = 7'b1111011;
            default: return 32'h0000_0013;
        endcase
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    // Monitor: stall is sampled mid-cycle, ID/EX just after each rising edge.
    initial begin
        slot_t e;
        bit    s;
        forever begin
            @(negedge clk);
            #2;
            if (stall_exp_q.size() > 0) begin
                s = stall_exp_q.pop_front();
                checkOutput("stall", 192'(stall), 192'(s));
            end
            @(posedge clk);
            #1;
            if (idex_exp_q.size() > 0) begin
                e = idex_exp_q.pop_front();
                checkOutput("idex", 192'(sample_dut()), 192'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ins;
        logic [31:0] pc;
        rst_n       = 1'b0;
        instruccion = 32'h0000_0013;
        pc4         = '0;
        flush       = 1'b1;
        wb_en       = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        model_reset();
        #3;
        checkOutput("reset_idex", 192'(sample_dut()), 192'(0));
        checkOutput("reset_stall", 192'(stall), 192'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h0002_8333, 32'h104, 0, 1, 5'd5, 32'hDEAD_BEEF);
        @(posedge clk); #2;
        checkOutput("bypass_rs1_data", 192'(id_rs1_data), 192'(32'hDEAD_BEEF));
        checkOutput("bypass_rd", 192'(id_rd), 192'(6));
        checkOutput("bypass_regwrite", 192'(id_regwrite), 192'(1));

        applyStimulus(32'h0000_0013, 32'h108, 0, 1, 5'd0, 32'h0000_1234);
        applyStimulus(32'h0000_0093, 32'h10C, 0, 0, 5'd0, 32'h0);
        @(posedge clk); #2;
        checkOutput("x0_rs1_data", 192'(id_rs1_data), 192'(0));

        applyStimulus(32'hFE20_AE23, 32'h110, 0, 0, 5'd0, 32'h0);
        @(posedge clk); #2;
        checkOutput("sw_imm", 192'(id_imm), 192'(32'hFFFF_FFFC));
        checkOutput("sw_memwrite", 192'(id_memwrite), 192'(1));
        applyStimulus(32'hFF9F_F0EF, 32'h114, 0, 0, 5'd0, 32'h0);
        @(posedge clk); #2;
        checkOutput("jal_imm", 192'(id_imm), 192'(32'hFFFF_FFF8));
        checkOutput("jal_jump", 192'(id_jump), 192'(1));

        applyStimulus(32'h0000_A183, 32'h118, 0, 0, 5'd0, 32'h0);
        applyStimulus(32'h0021_8233, 32'h11C, 0, 0, 5'd0, 32'h0);
        #2;
        checkOutput("loaduse_stall", 192'(stall), 192'(1));
        @(posedge clk); #2;
        checkOutput("loaduse_bubble", 192'(id_valid), 192'(0));
        applyStimulus(32'h0021_8233, 32'h11C, 0, 0, 5'd0, 32'h0);
        #2;
        checkOutput("loaduse_release", 192'(stall), 192'(0));
        @(posedge clk); #2;
        checkOutput("loaduse_add_rd", 192'(id_rd), 192'(4));

        applyStimulus(32'h0000_A183, 32'h120, 0, 0, 5'd0, 32'h0);
        applyStimulus(32'h0020_8233, 32'h124, 0, 0, 5'd0, 32'h0);
        #2;
        checkOutput("nohazard_stall", 192'(stall), 192'(0));

        applyStimulus(32'h0000_A183, 32'h128, 0, 0, 5'd0, 32'h0);
        applyStimulus(32'h0021_8233, 32'h12C, 1, 0, 5'd0, 32'h0);
        #2;
        checkOutput("flush_stall", 192'(stall), 192'(0));
        @(posedge clk); #2;
        checkOutput("flush_bubble", 192'(sample_dut()), 192'(0));

        applyStimulus(32'h0000_007F, 32'h130, 0, 0, 5'd0, 32'h0);
        @(posedge clk); #2;
        checkOutput("illegal_flag", 192'(id_illegal), 192'(1));
        checkOutput("illegal_valid", 192'(id_valid), 192'(1));

        applyStimulus(32'h0000_0013, 32'h134, 0, 1, 5'd5, 32'h0000_CAFE);
        @(posedge clk); #3;
        rst_n = 1'b0;
        flush = 1'b1;
        wb_en = 1'b0;
        #1;
        checkOutput("midreset_idex", 192'(sample_dut()), 192'(0));
        checkOutput("midreset_stall", 192'(stall), 192'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h0002_8333, 32'h200, 0, 0, 5'd0, 32'h0);
        @(posedge clk); #2;
        checkOutput("midreset_x5", 192'(id_rs1_data), 192'(0));

        ins = 32'h0000_0013;
        pc  = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                ins = gen_instr();
                pc  = pc + 4;
            end
            applyStimulus(ins, pc, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), $urandom);
        end

        @(posedge clk); #5;
        checkOutput("queue_drain", 192'(idex_exp_q.size() + stall_exp_q.size()), 192'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
